// File: rtl/dac_spi_pkg.sv
// +--------------------------------------------------------------------+
// | dac_spi_pkg                                                        |
// | Shared constants and state encoding for the SPI DAC serializer.    |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
`default_nettype none

package dac_spi_pkg;

   localparam int FRAME_BITS   = 16;
   localparam int DATA_BITS    = 12;
   localparam int CFG_BITS     = 4;
   localparam int HALF_PERIODS = 2 * FRAME_BITS;

   // Channel A, buffered Vref, gain 1x, output active
   localparam logic [CFG_BITS-1:0] CFG_WORD_DEFAULT = 4'b0111;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      SETUP  = 3'd1,
      SHIFT  = 3'd2,
      HOLD   = 3'd3,
      LATCH  = 3'd4,
      FINISH = 3'd5
   } state_t;

endpackage

`default_nettype wire

// File: rtl/dac_spi_tick_gen.sv
// +--------------------------------------------------------------------+
// | dac_spi_tick_gen                                                   |
// | Emits a 1-cycle tick every CLK_DIV cycles; restart re-phases it.   |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
`default_nettype none

module dac_spi_tick_gen #(
   parameter int CLK_DIV = 4
) (
   input  logic CLK,
   input  logic RST,
   input  logic restart,
   output logic tick
);

   localparam int            CW   = $clog2(CLK_DIV + 1);
   localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q + CW'(1);
      if (restart || (cnt_q == LAST)) begin
         cnt_d = '0;
      end
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign tick = (cnt_q == LAST);

endmodule

`default_nettype wire

// File: rtl/dac_spi_serializer.sv
// +--------------------------------------------------------------------+
// | dac_spi_serializer                                                 |
// | MCP4921-style 16-bit SPI frame + LDAC_N pulse, one pending slot.   |
// | Option macro: DAC_SPI_AUTO_UPDATE_EN (send on every DATA change).  |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
`default_nettype none

module dac_spi_serializer
   import dac_spi_pkg::*;
#(
   parameter int                  CLK_DIV  = 4,
   parameter logic [CFG_BITS-1:0] CFG_WORD = CFG_WORD_DEFAULT
) (
   input  logic                 CLK,
   input  logic                 RST,
   input  logic [DATA_BITS-1:0] DATA,
   input  logic                 START,
   output logic                 SCLK,
   output logic                 CS_N,
   output logic                 MOSI,
   output logic                 LDAC_N,
   output logic                 BUSY,
   output logic                 DONE,
   output logic                 PENDING
);

   if ((CLK_DIV < 1) || (CLK_DIV > 255)) begin : g_bad_clk_div
      $error("dac_spi_serializer: CLK_DIV must be in 1..255");
   end

   state_t                  state_q, state_d;
   logic [FRAME_BITS-1:0]   shift_q, shift_d;
   logic [DATA_BITS-1:0]    pend_q, pend_d;
   logic                    pending_q, pending_d;
   logic [5:0]              half_q, half_d;
   logic                    sclk_q, sclk_d;
   logic                    cs_n_q, cs_n_d;
   logic                    ldac_n_q, ldac_n_d;
   logic                    done_q, done_d;
   logic                    tick;
   logic                    req;
   logic                    load;

`ifdef DAC_SPI_AUTO_UPDATE_EN
   logic [DATA_BITS-1:0]    last_sent_q;

   // A changed code raises a one-cycle request, handled exactly like START
   assign req = START || (DATA != last_sent_q);

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         last_sent_q <= '0;
      end else begin
         last_sent_q <= DATA;
      end
   end
`else
   assign req = START;
`endif

   dac_spi_tick_gen #(
      .CLK_DIV (CLK_DIV)
   ) u_tick_gen (
      .CLK     (CLK),
      .RST     (RST),
      .restart (state_d != state_q),
      .tick    (tick)
   );

   always_comb begin
      state_d   = state_q;
      shift_d   = shift_q;
      pend_d    = pend_q;
      pending_d = pending_q;
      half_d    = half_q;
      sclk_d    = sclk_q;
      load      = 1'b0;

      case (state_q)
         IDLE:   load = req || pending_q;
         SETUP:  if (tick) state_d = SHIFT;
         SHIFT: begin
            if (tick) begin
               if (half_q != 6'(HALF_PERIODS)) half_d = half_q + 6'd1;
               if (!half_q[0]) begin
                  sclk_d = 1'b1;
               end else begin
                  sclk_d  = 1'b0;
                  shift_d = {shift_q[FRAME_BITS-2:0], 1'b0};
               end
               if (half_q == 6'(HALF_PERIODS - 1)) state_d = HOLD;
            end
         end
         HOLD:   if (tick) state_d = LATCH;
         LATCH:  if (tick) state_d = FINISH;
         FINISH: begin
            load = req || pending_q;
            if (!load) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      // A fresh request overrides the buffered one: last value wins
      if (load) begin
         state_d   = SETUP;
         shift_d   = {CFG_WORD, (req ? DATA : pend_q)};
         half_d    = '0;
         sclk_d    = 1'b0;
         pending_d = 1'b0;
      end else if (req && (state_q != IDLE)) begin
         pend_d    = DATA;
         pending_d = 1'b1;
      end

      cs_n_d   = !((state_d == SETUP) || (state_d == SHIFT) || (state_d == HOLD));
      ldac_n_d = (state_d != LATCH);
      done_d   = (state_d == FINISH);
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q   <= IDLE;
         shift_q   <= '0;
         pend_q    <= '0;
         pending_q <= 1'b0;
         half_q    <= '0;
         sclk_q    <= 1'b0;
         cs_n_q    <= 1'b1;
         ldac_n_q  <= 1'b1;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         shift_q   <= shift_d;
         pend_q    <= pend_d;
         pending_q <= pending_d;
         half_q    <= half_d;
         sclk_q    <= sclk_d;
         cs_n_q    <= cs_n_d;
         ldac_n_q  <= ldac_n_d;
         done_q    <= done_d;
      end
   end

   assign SCLK    = sclk_q;
   assign CS_N    = cs_n_q;
   assign MOSI    = shift_q[FRAME_BITS-1];
   assign LDAC_N  = ldac_n_q;
   assign BUSY    = (state_q != IDLE);
   assign DONE    = done_q;
   assign PENDING = pending_q;

endmodule

`default_nettype wire

// File: tb/tb_dac_spi_serializer.sv
// +--------------------------------------------------------------------+
// | tb_dac_spi_serializer                                              |
// | Directed, table-driven bench for two serializer instances (DIV 2/1)|
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_dac_spi_serializer;

   logic        CLK = 1'b0;
   logic        RST;
   always #5 CLK = ~CLK;

   logic [11:0] d2_data, d1_data;
   logic        d2_start, d1_start;
   logic        d2_sclk, d2_cs_n, d2_mosi, d2_ldac_n, d2_busy, d2_done, d2_pend;
   logic        d1_sclk, d1_cs_n, d1_mosi, d1_ldac_n, d1_busy, d1_done, d1_pend;

   dac_spi_serializer #(.CLK_DIV(2)) u_dut2 (
      .CLK(CLK), .RST(RST), .DATA(d2_data), .START(d2_start),
      .SCLK(d2_sclk), .CS_N(d2_cs_n), .MOSI(d2_mosi), .LDAC_N(d2_ldac_n),
      .BUSY(d2_busy), .DONE(d2_done), .PENDING(d2_pend)
   );

   dac_spi_serializer #(.CLK_DIV(1)) u_dut1 (
      .CLK(CLK), .RST(RST), .DATA(d1_data), .START(d1_start),
      .SCLK(d1_sclk), .CS_N(d1_cs_n), .MOSI(d1_mosi), .LDAC_N(d1_ldac_n),
      .BUSY(d1_busy), .DONE(d1_done), .PENDING(d1_pend)
   );

   int   sel;
   logic o_sclk, o_cs_n, o_mosi, o_ldac_n, o_busy, o_done, o_pend;

   always_comb begin
      if (sel == 1) {o_sclk, o_cs_n, o_mosi, o_ldac_n, o_busy, o_done, o_pend} =
         {d1_sclk, d1_cs_n, d1_mosi, d1_ldac_n, d1_busy, d1_done, d1_pend};
      else          {o_sclk, o_cs_n, o_mosi, o_ldac_n, o_busy, o_done, o_pend} =
         {d2_sclk, d2_cs_n, d2_mosi, d2_ldac_n, d2_busy, d2_done, d2_pend};
   end

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   // Results of the most recent monitor window
   logic [31:0] m_bits;
   int m_rises, m_cs_low, m_ldac_low, m_first_ldac, m_done, m_first_done;
   int m_busy_low, m_busy_gap, m_viol;

   // Call at the first falling edge after the request edge (k = 1)
   task automatic monitor(input int ncycles);
      logic prev;
      prev = 1'b0;
      m_bits = '0; m_rises = 0; m_cs_low = 0; m_ldac_low = 0; m_first_ldac = 0;
      m_done = 0; m_first_done = 0; m_busy_low = 0; m_busy_gap = 0; m_viol = 0;
      for (int k = 1; k <= ncycles; k++) begin
         if (k > 1) @(negedge CLK);
         if (o_sclk && !prev) begin
            m_bits = {m_bits[30:0], o_mosi};
            m_rises++;
         end
         prev = o_sclk;
         if (!o_cs_n) m_cs_low++;
         if (!o_ldac_n) begin
            m_ldac_low++;
            if (m_first_ldac == 0) m_first_ldac = k;
         end
         if (!o_busy) m_busy_low++;
         if (o_done) begin
            m_done++;
            if (m_first_done == 0) m_first_done = k;
            m_busy_gap = m_busy_low;
         end
         if ((o_cs_n && o_sclk) || (!o_ldac_n && !o_cs_n)) m_viol++;
      end
   endtask

   task automatic pulse_start(input int s, input logic [11:0] d);
      @(negedge CLK);
      if (s == 1) begin d1_data = d; d1_start = 1'b1; end
      else        begin d2_data = d; d2_start = 1'b1; end
      @(negedge CLK);
      d1_start = 1'b0;
      d2_start = 1'b0;
   endtask

   task automatic run_frame(input int s, input logic [11:0] d, input logic [15:0] exp);
      int div;
      div = (s == 1) ? 1 : 2;
      sel = s;
      pulse_start(s, d);
      monitor(35 * div + 4);
      check($sformatf("frame_%03h_bits", d), {16'h0, m_bits[15:0]}, {16'h0, exp});
      check("sclk_rises", m_rises, 16);
      check("cs_low_cycles", m_cs_low, 34 * div);
      check("ldac_low_cycles", m_ldac_low, div);
      check("ldac_start", m_first_ldac, 34 * div + 1);
      check("done_pulses", m_done, 1);
      check("done_latency", m_first_done, 35 * div + 1);
      check("idle_pin_violations", m_viol, 0);
      check("busy_gap", m_busy_gap, 0);
      check("idle_after_frame", {o_busy, o_cs_n, o_sclk}, 3'b010);
   endtask

   typedef struct {
      int          s;
      logic [11:0] data;
      logic [15:0] frame;
   } vec_t;

   vec_t vecs[6];

   initial begin
      #1_000_000;
      $display("FAIL global_timeout: got expired expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      vecs[0] = '{2, 12'hA5C, 16'h7A5C};
      vecs[1] = '{1, 12'hFFF, 16'h7FFF};
      vecs[2] = '{1, 12'h000, 16'h7000};
      vecs[3] = '{2, 12'h3C3, 16'h73C3};
      vecs[4] = '{1, 12'h5A5, 16'h75A5};
      vecs[5] = '{2, 12'h801, 16'h7801};

      sel = 2;
      RST = 1'b0;
      d2_data = '0; d1_data = '0; d2_start = 1'b0; d1_start = 1'b0;
      repeat (3) @(negedge CLK);
      check("reset_outputs_div2",
            {d2_sclk, d2_cs_n, d2_mosi, d2_ldac_n, d2_busy, d2_done, d2_pend}, 7'b0101000);
      check("reset_outputs_div1",
            {d1_sclk, d1_cs_n, d1_mosi, d1_ldac_n, d1_busy, d1_done, d1_pend}, 7'b0101000);
      RST = 1'b1;
      repeat (3) @(negedge CLK);

      for (int i = 0; i < 6; i++) begin
         run_frame(vecs[i].s, vecs[i].data, vecs[i].frame);
         repeat (3) @(negedge CLK);
      end

      // Two overwriting STARTs during SHIFT: only the last one is sent
      sel = 2;
      pulse_start(2, 12'h123);
      fork
         monitor(145);
         begin
            repeat (10) @(negedge CLK);
            d2_data = 12'h456; d2_start = 1'b1;
            @(negedge CLK);
            d2_data = 12'h789;
            @(negedge CLK);
            d2_start = 1'b0;
            check("pending_set", o_pend, 1'b1);
         end
      join
      check("b2b_bits", m_bits, {16'h7123, 16'h7789});
      check("b2b_rises", m_rises, 32);
      check("b2b_done_pulses", m_done, 2);
      check("b2b_first_done", m_first_done, 71);
      check("b2b_busy_gap", m_busy_gap, 0);
      check("b2b_cs_low", m_cs_low, 136);
      check("b2b_pending_clear", o_pend, 1'b0);
      repeat (3) @(negedge CLK);

      // Asynchronous reset on the 7th SCLK rise
      begin
         int  rises;
         bit  hit;
         logic prev;
         rises = 0; hit = 0; prev = 1'b0;
         sel = 2;
         pulse_start(2, 12'hABC);
         for (int k = 0; k < 100 && !hit; k++) begin
            if (k > 0) @(negedge CLK);
            if (d2_sclk && !prev) rises++;
            prev = d2_sclk;
            if (rises == 7) begin
               hit = 1;
               check("pre_reset_sclk_high", d2_sclk, 1'b1);
               RST = 1'b0;
               #1;
               check("midframe_reset_outputs",
                     {d2_sclk, d2_cs_n, d2_mosi, d2_busy, d2_pend, d2_ldac_n}, 6'b010001);
            end
         end
         if (!hit) check("reach_7th_rise", 0, 1);
         @(negedge CLK);
         d2_data = '0;
         RST = 1'b1;
         repeat (3) @(negedge CLK);
         check("no_resume_after_reset", d2_busy, 1'b0);
         run_frame(2, 12'h001, 16'h7001);
      end

`ifdef DAC_SPI_AUTO_UPDATE_EN
      sel = 2;
      repeat (3) @(negedge CLK);
      d2_data = 12'h3E8;
      @(negedge CLK);
      monitor(75);
      check("auto_bits", {16'h0, m_bits[15:0]}, 32'h73E8);
      check("auto_done", m_done, 1);
      @(negedge CLK);
      monitor(40);
      check("auto_quiet", m_cs_low, 0);
      d2_data = 12'h0AA;
      @(negedge CLK);
      fork
         monitor(145);
         begin
            repeat (19) @(negedge CLK);
            d2_data = 12'h155;
         end
      join
      check("auto_followup_bits", m_bits, {16'h70AA, 16'h7155});
      check("auto_followup_done", m_done, 2);
      @(negedge CLK);
      monitor(40);
      check("auto_quiet_after", m_cs_low, 0);
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

`default_nettype wire
